// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared states, protocol constants and CRC helper for the SD sector writer
package sd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_R1,
        ST_GAP,
        ST_TOKEN,
        ST_DATA,
        ST_CRC,
        ST_DRESP,
        ST_BUSYW,
        ST_FIN,
        ST_ERR
    } wr_state_e;

    typedef enum logic [2:0] {
        ERR_NONE         = 3'd0,
        ERR_R1_TIMEOUT   = 3'd1,
        ERR_R1_NONZERO   = 3'd2,
        ERR_DATA_REJECT  = 3'd3,
        ERR_BUSY_TIMEOUT = 3'd4
    } err_code_e;

    localparam logic [7:0] CMD24_BYTE   = 8'h58;
    localparam logic [7:0] START_TOKEN  = 8'hFE;
    localparam logic [7:0] DRESP_ACCEPT = 8'h05;
    localparam logic [7:0] IDLE_BYTE    = 8'hFF;
    localparam int         SECTOR_BYTES = 512;

    // CRC-16-CCITT, poly 0x1021, one data byte folded in MSB first
    function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_sector_write_if.sv
// rtl/sd_sector_write_if.sv - host control and sector byte stream of the SD sector writer
interface sd_sector_write_if;
    logic        start;
    logic [31:0] sector_addr;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  err_code;

    modport master (
        output start, sector_addr, din, din_valid,
        input  din_ready, busy, done, err, err_code
    );

    modport slave (
        input  start, sector_addr, din, din_valid,
        output din_ready, busy, done, err, err_code
    );
endinterface

// File: rtl/sd_spi_byte.sv
// rtl/sd_spi_byte.sv - SPI mode-0 byte engine, MSB first, SD_clk idles low between bytes
module sd_spi_byte #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go_i,
    input  logic [7:0] tx_i,
    input  logic       miso_i,
    output logic [7:0] rx_o,
    output logic       byte_done_o,
    output logic       busy_o,
    output logic       sclk_o,
    output logic       mosi_o
);
    localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

    logic          active_q;
    logic [DW-1:0] div_q;
    logic [2:0]    bit_q;
    logic          sclk_q;
    logic [7:0]    tx_q;
    logic [7:0]    rx_q;
    logic          done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            sclk_q   <= 1'b0;
            tx_q     <= 8'hFF;
            rx_q     <= 8'h00;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!active_q) begin
                if (go_i) begin
                    active_q <= 1'b1;
                    tx_q     <= tx_i;
                    div_q    <= '0;
                    bit_q    <= '0;
                end
            end else if (div_q == DIV_LAST) begin
                div_q <= '0;
                if (!sclk_q) begin
                    // rising edge: capture MISO
                    sclk_q <= 1'b1;
                    rx_q   <= {rx_q[6:0], miso_i};
                end else begin
                    // falling edge: present the next MOSI bit
                    sclk_q <= 1'b0;
                    tx_q   <= {tx_q[6:0], 1'b1};
                    bit_q  <= bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
            end else begin
                div_q <= div_q + DW'(1);
            end
        end
    end

    assign rx_o        = rx_q;
    assign byte_done_o = done_q;
    assign busy_o      = active_q;
    assign sclk_o      = sclk_q;
    assign mosi_o      = active_q ? tx_q[7] : 1'b1;

endmodule

// File: rtl/sd_sector_write.sv
// rtl/sd_sector_write.sv - SPI-mode SD CMD24 single-block writer; SD_WR_CRC16_EN enables the data CRC
module sd_sector_write
    import sd_pkg::*;
#(
    parameter int CLK_DIV      = 2,
    parameter int RESP_TIMEOUT = 8,
    parameter int BUSY_TIMEOUT = 65535
) (
    input  logic               clk_50M,
    input  logic               reset_n,
    sd_sector_write_if.slave   host,
    output logic               SD_clk,
    output logic               SD_cs,
    output logic               SD_datain,
    input  logic               SD_dataout
);
    localparam logic [15:0] RESP_LAST = 16'(RESP_TIMEOUT - 1);
    localparam logic [15:0] BUSY_LAST = 16'(BUSY_TIMEOUT - 1);
    localparam logic [8:0]  DATA_LAST = 9'(SECTOR_BYTES - 1);

    wr_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [8:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] addr_q, addr_d;
    err_code_e   err_code_q, err_code_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        go;
    logic [7:0]  tx_byte;
    logic [7:0]  rx_byte;
    logic        byte_done;
    logic        eng_busy;
    logic        engine_free;
    logic        din_ready;

    sd_spi_byte #(.CLK_DIV(CLK_DIV)) u_spi (
        .clk         (clk_50M),
        .rst_n       (reset_n),
        .go_i        (go),
        .tx_i        (tx_byte),
        .miso_i      (SD_dataout),
        .rx_o        (rx_byte),
        .byte_done_o (byte_done),
        .busy_o      (eng_busy),
        .sclk_o      (SD_clk),
        .mosi_o      (SD_datain)
    );

`ifdef SD_WR_CRC16_EN
    logic [15:0] crc_q;

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= 16'h0000;
        end else if (state_q == ST_IDLE) begin
            crc_q <= 16'h0000;
        end else if (state_q == ST_DATA && go) begin
            crc_q <= crc16_ccitt_byte(crc_q, host.din);
        end
    end
`endif

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            err_code_q <= ERR_NONE;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            err_code_q <= err_code_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // A new byte is only issued once the previous byte_done has been consumed
    assign engine_free = !eng_busy && !byte_done;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        err_code_d = err_code_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        go         = 1'b0;
        tx_byte    = IDLE_BYTE;
        din_ready  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (host.start && !done_q && !err_q) begin
                    addr_d     = host.sector_addr;
                    err_code_d = ERR_NONE;
                    state_d    = ST_CMD;
                end
            end
            ST_CMD: begin
                case (cnt_q[2:0])
                    3'd0:    tx_byte = CMD24_BYTE;
                    3'd1:    tx_byte = addr_q[31:24];
                    3'd2:    tx_byte = addr_q[23:16];
                    3'd3:    tx_byte = addr_q[15:8];
                    3'd4:    tx_byte = addr_q[7:0];
                    default: tx_byte = IDLE_BYTE;
                endcase
                go = engine_free;
                if (byte_done) begin
                    if (cnt_q == 16'd5) state_d = ST_R1;
                    else                cnt_d   = cnt_q + 16'd1;
                end
            end
            ST_R1: begin
                go = engine_free;
                if (byte_done) begin
                    if (!rx_byte[7]) begin
                        if (rx_byte == 8'h00) begin
                            state_d = ST_GAP;
                        end else begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_R1_NONZERO;
                        end
                    end else if (cnt_q == RESP_LAST) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_R1_TIMEOUT;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ST_GAP: begin
                go = engine_free;
                if (byte_done) state_d = ST_TOKEN;
            end
            ST_TOKEN: begin
                tx_byte = START_TOKEN;
                go      = engine_free;
                if (byte_done) begin
                    state_d    = ST_DATA;
                    byte_cnt_d = '0;
                end
            end
            ST_DATA: begin
                din_ready = engine_free;
                tx_byte   = host.din;
                go        = engine_free && host.din_valid;
                if (byte_done) begin
                    if (byte_cnt_q == DATA_LAST) state_d    = ST_CRC;
                    else                         byte_cnt_d = byte_cnt_q + 9'd1;
                end
            end
            ST_CRC: begin
`ifdef SD_WR_CRC16_EN
                tx_byte = cnt_q[0] ? crc_q[7:0] : crc_q[15:8];
`else
                tx_byte = IDLE_BYTE;
`endif
                go = engine_free;
                if (byte_done) begin
                    if (cnt_q == 16'd1) state_d = ST_DRESP;
                    else                cnt_d   = cnt_q + 16'd1;
                end
            end
            ST_DRESP: begin
                go = engine_free;
                if (byte_done) begin
                    // a token has the shape xxx0xxx1; any other byte is still idle bus
                    if (!rx_byte[4] && rx_byte[0]) begin
                        if (rx_byte[4:0] == DRESP_ACCEPT[4:0]) begin
                            state_d = ST_BUSYW;
                        end else begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_DATA_REJECT;
                        end
                    end else if (cnt_q == RESP_LAST) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_DATA_REJECT;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ST_BUSYW: begin
                go = engine_free;
                if (byte_done) begin
                    if (rx_byte == 8'hFF) begin
                        state_d = ST_FIN;
                    end else if (cnt_q == BUSY_LAST) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_BUSY_TIMEOUT;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ST_FIN: begin
                go = engine_free;
                if (byte_done) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_ERR: begin
                go = engine_free;
                if (byte_done) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;
    end

    assign SD_cs          = (state_q == ST_IDLE) || (state_q == ST_FIN) || (state_q == ST_ERR);
    assign host.din_ready = din_ready;
    assign host.busy      = (state_q != ST_IDLE);
    assign host.done      = done_q;
    assign host.err       = err_q;
    assign host.err_code  = err_code_q;

endmodule

// File: tb/tb_sd_sector_write.sv
// tb/tb_sd_sector_write.sv - self-checking bench for sd_sector_write with a byte-level SD card model
module tb_sd_sector_write;
    localparam int CLK_DIV      = 1;
    localparam int RESP_TIMEOUT = 8;
    localparam int BUSY_TIMEOUT = 16;

    logic clk_50M = 1'b0;
    logic reset_n = 1'b0;
    logic SD_clk, SD_cs, SD_datain;
    logic SD_dataout = 1'b1;

    sd_sector_write_if host();

    sd_sector_write #(.CLK_DIV(CLK_DIV), .RESP_TIMEOUT(RESP_TIMEOUT), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk_50M    (clk_50M),
        .reset_n    (reset_n),
        .host       (host),
        .SD_clk     (SD_clk),
        .SD_cs      (SD_cs),
        .SD_datain  (SD_datain),
        .SD_dataout (SD_dataout)
    );

    always #10 clk_50M = ~clk_50M;

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    // card configuration, written by the stimulus
    bit         cfg_r1_en;
    int         cfg_r1_delay;
    logic [7:0] cfg_r1_val;
    logic [7:0] cfg_dresp;
    int         cfg_busy;
    bit         cfg_busy_forever;

    // card state, written only by the card process
    logic [7:0] c_rx = 8'hFF, c_tx = 8'hFF;
    int         c_bit = 0, c_ph = 0, c_nb = 0, c_pi = 0, c_bi = 0;
    logic       c_prev_cs = 1'b1;
    logic [7:0] c_cmd [6];
    logic [7:0] c_sector [512];
    logic [7:0] c_crc [2];
    int         sess_cnt = 0, r1_polls = 0, busy_polls = 0, trail_cnt = 0;

    task card_byte();
        if (SD_cs) begin
            trail_cnt++;
            c_tx = 8'hFF;
        end else begin
            case (c_ph)
                0: begin c_cmd[c_nb] = c_rx; c_nb++; if (c_nb == 6) begin c_ph = 1; c_nb = 0; end end
                1: if (c_rx == 8'hFE) c_ph = 2; else begin r1_polls++; c_pi++; end
                2: begin c_sector[c_nb] = c_rx; c_nb++; if (c_nb == 512) begin c_ph = 3; c_nb = 0; end end
                3: begin c_crc[c_nb] = c_rx; c_nb++; if (c_nb == 2) c_ph = 4; end
                4: begin c_ph = 5; c_bi = 0; end
                default: begin busy_polls++; c_bi++; end
            endcase
            case (c_ph)
                1:       c_tx = (cfg_r1_en && c_pi == cfg_r1_delay) ? cfg_r1_val : 8'hFF;
                4:       c_tx = cfg_dresp;
                5:       c_tx = (cfg_busy_forever || c_bi < cfg_busy) ? 8'h00 : 8'hFF;
                default: c_tx = 8'hFF;
            endcase
        end
    endtask

    always @(posedge SD_clk or negedge SD_clk or SD_cs) begin
        if (SD_cs !== c_prev_cs) begin
            c_prev_cs = SD_cs;
            if (SD_cs === 1'b0) begin
                sess_cnt++;
                c_ph = 0; c_nb = 0; c_pi = 0; c_bi = 0; c_bit = 0;
                r1_polls = 0; busy_polls = 0; trail_cnt = 0;
                c_tx = 8'hFF;
                SD_dataout = 1'b1;
            end
        end else if (SD_clk === 1'b1) begin
            c_rx = {c_rx[6:0], SD_datain};
            c_bit++;
        end else if (c_bit == 8) begin
            c_bit = 0;
            card_byte();
            SD_dataout = c_tx[7];
        end else begin
            c_tx = {c_tx[6:0], 1'b1};
            SD_dataout = c_tx[7];
        end
    end

    int done_total = 0, err_total = 0;
    always @(negedge clk_50M) begin
        if (host.done === 1'b1) done_total++;
        if (host.err === 1'b1)  err_total++;
    end

    logic [7:0] src [512];
    int run_done, run_err, run_extra, run_stall_hi, run_stall_idle, run_sess;

    task automatic set_card(input bit r1_en, input int r1_delay, input logic [7:0] r1_val,
                            input logic [7:0] dresp, input int busy, input bit forever_busy);
        cfg_r1_en = r1_en; cfg_r1_delay = r1_delay; cfg_r1_val = r1_val;
        cfg_dresp = dresp; cfg_busy = busy; cfg_busy_forever = forever_busy;
    endtask

    task automatic run_write(input logic [31:0] addr, input int stall_at, input int stall_len, input int reset_at);
        int idx = 0, stall = stall_len, cyc = 0, d0 = done_total, e0 = err_total, s0 = sess_cnt;
        bit fin = 0;
        run_extra = 0; run_stall_hi = 0; run_stall_idle = 0;
        @(negedge clk_50M);
        host.start = 1'b1; host.sector_addr = addr;
        while (!fin && cyc < 20000) begin
            @(negedge clk_50M);
            cyc++;
            host.start = (cyc == 100);
            if (host.done === 1'b1 || host.err === 1'b1) begin
                fin = 1;
                host.start = 1'b1;
                host.din_valid = 1'b0;
            end else if (reset_at >= 0 && idx == reset_at && host.din_ready === 1'b1) begin
                reset_n = 1'b0;
                #1;
                check("rst_cs", SD_cs, 1'b1);
                check("rst_sclk", SD_clk, 1'b0);
                check("rst_mosi", SD_datain, 1'b1);
                check("rst_busy", host.busy, 1'b0);
                check("rst_done", host.done, 1'b0);
                check("rst_err", host.err, 1'b0);
                check("rst_code", host.err_code, 3'd0);
                check("rst_ready", host.din_ready, 1'b0);
                @(negedge clk_50M);
                reset_n = 1'b1;
                fin = 1;
            end else begin
                if (idx == stall_at && stall > 0) begin
                    host.din_valid = 1'b0;
                    stall--;
                    if (host.din_ready === 1'b1) begin
                        run_stall_idle++;
                        if (SD_clk !== 1'b0) run_stall_hi++;
                    end
                end else begin
                    host.din_valid = (idx < 512);
                end
                host.din = src[(idx < 512) ? idx : 0];
                if (host.din_ready === 1'b1 && (idx >= 512 || SD_cs !== 1'b0)) run_extra++;
                if (host.din_valid && host.din_ready === 1'b1) idx++;
            end
        end
        check("timeout", fin, 1'b1);
        @(negedge clk_50M);
        host.start = 1'b0; host.din_valid = 1'b0;
        repeat (40) @(negedge clk_50M);
        run_done = done_total - d0;
        run_err  = err_total - e0;
        run_sess = sess_cnt - s0;
    endtask

    function automatic logic [15:0] ref_crc();
        logic [15:0] c = 16'h0000;
        for (int i = 0; i < 512; i++) begin
            c = c ^ {src[i], 8'h00};
            for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    task automatic check_idle_after();
        check("sessions", run_sess, 1);
        check("cs_idle", SD_cs, 1'b1);
        check("busy_idle", host.busy, 1'b0);
        check("trail", trail_cnt, 1);
        check("extra_ready", run_extra, 0);
    endtask

    task automatic check_success(input logic [31:0] addr, input int r1_delay, input int busy);
        int bad = 0;
        logic [15:0] exp_crc;
        check("cmd0", c_cmd[0], 8'h58);
        check("cmd1", c_cmd[1], addr[31:24]);
        check("cmd2", c_cmd[2], addr[23:16]);
        check("cmd3", c_cmd[3], addr[15:8]);
        check("cmd4", c_cmd[4], addr[7:0]);
        check("cmd5", c_cmd[5], 8'hFF);
        for (int i = 0; i < 512; i++) if (c_sector[i] !== src[i]) bad++;
        check("sector", bad, 0);
`ifdef SD_WR_CRC16_EN
        exp_crc = ref_crc();
`else
        exp_crc = 16'hFFFF;
`endif
        check("crc", {c_crc[0], c_crc[1]}, exp_crc);
        check("r1_polls", r1_polls, r1_delay + 2);
        check("busy_polls", busy_polls, busy + 1);
        check("done_cnt", run_done, 1);
        check("err_cnt", run_err, 0);
        check("err_code", host.err_code, 3'd0);
        check_idle_after();
    endtask

    task automatic check_error(input logic [2:0] code);
        check("err_cnt", run_err, 1);
        check("done_cnt", run_done, 0);
        check("err_code", host.err_code, code);
        check_idle_after();
    endtask

    initial begin
        logic [31:0] addr;
        int d, b;
        host.start = 1'b0; host.sector_addr = '0; host.din = '0; host.din_valid = 1'b0;
        repeat (3) @(negedge clk_50M);
        check("init_cs", SD_cs, 1'b1);
        check("init_sclk", SD_clk, 1'b0);
        check("init_mosi", SD_datain, 1'b1);
        check("init_busy", host.busy, 1'b0);
        check("init_done", host.done, 1'b0);
        check("init_err", host.err, 1'b0);
        check("init_code", host.err_code, 3'd0);
        check("init_ready", host.din_ready, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_50M);

        // nominal write, incrementing pattern
        for (int i = 0; i < 512; i++) src[i] = 8'(i);
        set_card(1, 2, 8'h00, 8'hE5, 10, 0);
        run_write(32'h0000_1234, -1, 0, -1);
        check_success(32'h0000_1234, 2, 10);

        // randomized write with a source stall at byte 100
        for (int i = 0; i < 512; i++) src[i] = 8'($urandom_range(0, 255));
        addr = $urandom; d = $urandom_range(0, 7); b = $urandom_range(0, 15);
        set_card(1, d, 8'h00, 8'hE5, b, 0);
        run_write(addr, 100, 40, -1);
        check_success(addr, d, b);
        check("stall_sclk", run_stall_hi, 0);
        check("stall_seen", run_stall_idle > 0, 1'b1);

        // card never answers R1
        set_card(0, 0, 8'h00, 8'hE5, 0, 0);
        run_write($urandom, -1, 0, -1);
        check_error(3'd1);
        check("r1_to_polls", r1_polls, RESP_TIMEOUT);

        // R1 with an error bit
        d = $urandom_range(0, 5);
        set_card(1, d, 8'h04, 8'hE5, 0, 0);
        run_write($urandom, -1, 0, -1);
        check_error(3'd2);
        check("r1_nz_polls", r1_polls, d + 1);

        // data response reports a CRC error
        set_card(1, 0, 8'h00, 8'h0B, 0, 0);
        run_write($urandom, -1, 0, -1);
        check_error(3'd3);
        check("rej_busy_polls", busy_polls, 0);

        // card stays busy forever
        set_card(1, 1, 8'h00, 8'hE5, 0, 1);
        run_write($urandom, -1, 0, -1);
        check_error(3'd4);
        check("busy_to_polls", busy_polls, BUSY_TIMEOUT);

        // reset during data byte 300, then a clean all-zero sector
        set_card(1, 1, 8'h00, 8'hE5, 3, 0);
        run_write($urandom, -1, 0, 300);
        check("rst_no_done", run_done, 0);
        check("rst_no_err", run_err, 0);
        for (int i = 0; i < 512; i++) src[i] = 8'h00;
        addr = $urandom; d = $urandom_range(0, 7); b = $urandom_range(0, 15);
        set_card(1, d, 8'h00, 8'h05, b, 0);
        run_write(addr, -1, 0, -1);
        check_success(addr, d, b);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
